img_stream_arbiter: RTL and testbench



---
 rtl/img_stream_arbiter_if.sv | 40 ++++
 rtl/img_stream_arbiter.sv | 149 ++++++++++++++
 tb/tb_img_stream_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/img_stream_arbiter_if.sv
// Stream bus between the N filter-engine slaves, the arbiter and the output
// FIFO write port. The slave modport is the arbiter's view; the master
// modport is the environment (slaves + FIFO + frame master).
interface img_stream_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DW     = 32,
  parameter int unsigned MODE_W = 2,
  parameter int unsigned PV_W   = 8
);
  localparam int unsigned IW = $clog2(NUM_CH);

  logic                     cfg_prio_en;
  logic [NUM_CH*MODE_W-1:0] slv_mode;
  logic [NUM_CH-1:0]        slv_data_valid;
  logic [NUM_CH*DW-1:0]     slv_data;
  logic [NUM_CH*PV_W-1:0]   slv_proc_val;
  logic [NUM_CH-1:0]        slv_ready;
  logic                     fifo_full;
  logic                     mstr_cmplt;
  logic                     slvx_data_valid;
  logic [DW-1:0]            slvx_data;
  logic [MODE_W-1:0]        slvx_mode;
  logic [PV_W-1:0]          slvx_proc_val;
  logic [IW-1:0]            slvx_ch_id;
  logic                     busy;

  modport slave (
    input  cfg_prio_en, slv_mode, slv_data_valid, slv_data, slv_proc_val,
           fifo_full, mstr_cmplt,
    output slv_ready, slvx_data_valid, slvx_data, slvx_mode, slvx_proc_val,
           slvx_ch_id, busy
  );

  modport master (
    output cfg_prio_en, slv_mode, slv_data_valid, slv_data, slv_proc_val,
           fifo_full, mstr_cmplt,
    input  slv_ready, slvx_data_valid, slvx_data, slvx_mode, slvx_proc_val,
           slvx_ch_id, busy
  );
endinterface

// File: rtl/img_stream_arbiter.sv
// N-channel pixel stream arbiter feeding the shared output FIFO write port.
// Round-robin or fixed-priority winner selection, bounded bursts, FIFO
// backpressure, frame-complete abort, per-beat source channel tag.
module img_stream_arbiter #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned MODE_W    = 2,
  parameter int unsigned PV_W      = 8,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  img_stream_arbiter_if.slave bus
);
  localparam int unsigned   CW        = $clog2(BURST_MAX + 1);
  localparam int unsigned   IW        = $clog2(NUM_CH);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CH - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_MAX - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     gnt_idx, gnt_nxt;
  logic [IW-1:0]     rr_ptr, rr_nxt;
  logic [IW-1:0]     win_idx;
  logic [CW-1:0]     beat_cnt, cnt_nxt;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] ready;
  logic              win_found;
  logic              xfer;
  logic              last_beat;
  logic [DW-1:0]     sel_data;
  logic [MODE_W-1:0] sel_mode;
  logic [PV_W-1:0]   sel_pv;

  // Request decode: any nonzero mode is a request.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      req[i] = |bus.slv_mode[i*MODE_W +: MODE_W];
    end
  end

  // Winner search: from index 0 in priority mode, from rr_ptr otherwise.
  always_comb begin
    int unsigned   j;
    logic [IW-1:0] jj;
    win_idx   = '0;
    win_found = 1'b0;
    j         = 0;
    jj        = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      j  = bus.cfg_prio_en ? k : (32'(rr_ptr) + k) % NUM_CH;
      jj = IW'(j);
      if (!win_found && req[jj]) begin
        win_idx   = jj;
        win_found = 1'b1;
      end
    end
  end

  // Accept strobe depends only on registers, fifo_full and mstr_cmplt.
  always_comb begin
    ready = '0;
    if ((state == GRANT) && !bus.fifo_full && !bus.mstr_cmplt) begin
      ready[gnt_idx] = 1'b1;
    end
  end

  assign bus.slv_ready = ready;
  assign bus.busy      = (state == GRANT);
  assign xfer          = |(ready & bus.slv_data_valid);
  assign last_beat     = xfer && (beat_cnt == LAST_BEAT);

  // Beat mux from the granted channel.
  always_comb begin
    sel_data = '0;
    sel_mode = '0;
    sel_pv   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_data = bus.slv_data[i*DW +: DW];
        sel_mode = bus.slv_mode[i*MODE_W +: MODE_W];
        sel_pv   = bus.slv_proc_val[i*PV_W +: PV_W];
      end
    end
  end

  // Next-state: grant on any request, release on last beat, drop or abort.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_idx;
    cnt_nxt   = beat_cnt;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (!bus.mstr_cmplt && win_found) begin
          state_nxt = GRANT;
          gnt_nxt   = win_idx;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          cnt_nxt = beat_cnt + 1'b1;
        end
        if (bus.mstr_cmplt || !req[gnt_idx] || last_beat) begin
          state_nxt = IDLE;
          rr_nxt    = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      gnt_idx  <= gnt_nxt;
      beat_cnt <= cnt_nxt;
      rr_ptr   <= rr_nxt;
    end
  end

  // Output beat registers: strobe every cycle, payload only on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.slvx_data_valid <= 1'b0;
      bus.slvx_data       <= '0;
      bus.slvx_mode       <= '0;
      bus.slvx_proc_val   <= '0;
      bus.slvx_ch_id      <= '0;
    end else begin
      bus.slvx_data_valid <= xfer;
      if (xfer) begin
        bus.slvx_data     <= sel_data;
        bus.slvx_mode     <= sel_mode;
        bus.slvx_proc_val <= sel_pv;
        bus.slvx_ch_id    <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_img_stream_arbiter.sv
// Bench for img_stream_arbiter: per-cycle ready/valid/busy expectations for
// directed scenarios plus a beat scoreboard fed by the slave source models.
module tb_img_stream_arbiter;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned DW        = 32;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned PV_W      = 8;
  localparam int unsigned BURST_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  img_stream_arbiter_if #(.NUM_CH(NUM_CH), .DW(DW), .MODE_W(MODE_W), .PV_W(PV_W)) bus ();

  img_stream_arbiter #(
    .NUM_CH(NUM_CH), .DW(DW), .MODE_W(MODE_W), .PV_W(PV_W), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [MODE_W-1:0] mode [NUM_CH];
  logic [NUM_CH-1:0] valid;
  logic [DW-1:0]     base [NUM_CH];
  logic [DW-1:0]     cnt  [NUM_CH] = '{default: '0};
  logic [63:0]       exp_q [$];
  int                n_vec = 0;
  int                n_err = 0;

  function automatic logic [PV_W-1:0] pv_of(input int ch, input logic [DW-1:0] c);
    return PV_W'(128 + ch * 16 + int'(c[3:0]));
  endfunction

  function automatic logic [63:0] beat_of(input int ch, input logic [MODE_W-1:0] m,
                                          input logic [PV_W-1:0] pv, input logic [DW-1:0] d);
    return {20'h0, 2'(ch), m, pv, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Check the current cycle at the falling edge, then move to just after the next rising edge.
  task automatic step(input string tag, input logic [3:0] rdy, input logic vld, input logic bsy);
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(bus.slv_ready), 64'(rdy));
    chk({tag, "_vld"}, 64'(bus.slvx_data_valid), 64'(vld));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(bsy));
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [MODE_W-1:0] m, input logic v);
    mode[ch]  = m;
    valid[ch] = v;
  endtask

  task automatic all_off();
    for (int i = 0; i < NUM_CH; i++) set_ch(i, '0, 1'b0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rdy"},  64'(bus.slv_ready), 64'd0);
    chk({tag, "_vld"},  64'(bus.slvx_data_valid), 64'd0);
    chk({tag, "_data"}, 64'(bus.slvx_data), 64'd0);
    chk({tag, "_mode"}, 64'(bus.slvx_mode), 64'd0);
    chk({tag, "_pv"},   64'(bus.slvx_proc_val), 64'd0);
    chk({tag, "_ch"},   64'(bus.slvx_ch_id), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  // Slave sources: data/proc_val come from a per-channel beat counter.
  always_comb begin
    bus.slv_mode       = '0;
    bus.slv_data       = '0;
    bus.slv_proc_val   = '0;
    bus.slv_data_valid = valid;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.slv_mode[i*MODE_W +: MODE_W]   = mode[i];
      bus.slv_data[i*DW +: DW]           = base[i] + cnt[i];
      bus.slv_proc_val[i*PV_W +: PV_W]   = pv_of(i, cnt[i]);
    end
  end

  // Each accepted beat is queued as the beat the FIFO port must show next.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.slv_ready[i] && valid[i]) begin
          exp_q.push_back(beat_of(i, mode[i], pv_of(i, cnt[i]), base[i] + cnt[i]));
          cnt[i] <= cnt[i] + 1;
        end
      end
    end
  end

  // FIFO-side monitor.
  always @(negedge clk) begin
    if (bus.slvx_data_valid) begin
      if (exp_q.size() == 0)
        chk("beat_unexpected_q_size", 64'(exp_q.size()), 64'd1);
      else
        chk("beat", {20'h0, bus.slvx_ch_id, bus.slvx_mode, bus.slvx_proc_val, bus.slvx_data},
            exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph;
    logic [3:0] r;
    rst = 1'b1;
    bus.cfg_prio_en = 1'b0;
    bus.fifo_full   = 1'b0;
    bus.mstr_cmplt  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      mode[i]  = '0;
      valid[i] = 1'b0;
      base[i]  = DW'(i) << 24;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1;

    // Round-robin: 0,1,2,3,... four beats each, one idle cycle between.
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 2'(i % 3 + 1), 1'b1);
    for (int k = 0; k < 40; k++) begin
      if (k == 2) mode[0] = 2'd3;  // nonzero mode change must not end the burst
      ph = k % 5;
      r  = (ph == 0) ? 4'b0000 : 4'(1 << ((k / 5) % 4));
      step("rr", r, (k >= 1) && ((k - 1) % 5 != 0), ph != 0);
    end
    all_off();
    step("rr_end", 4'b0000, 1'b1, 1'b0);
    step("rr_end", 4'b0000, 1'b0, 1'b0);
    chk("rr_drain", 64'(exp_q.size()), 64'd0);

    // Fixed priority: ch1 monopolises while requesting, then ch3.
    bus.cfg_prio_en = 1'b1;
    set_ch(1, 2'd1, 1'b1);
    set_ch(3, 2'd2, 1'b1);
    for (int k = 0; k < 10; k++) begin
      ph = k % 5;
      step("prio", (ph == 0) ? 4'b0000 : 4'b0010, (k >= 1) && ((k - 1) % 5 != 0), ph != 0);
    end
    set_ch(1, '0, 1'b0);
    step("prio_sw", 4'b0000, 1'b1, 1'b0);
    step("prio_sw", 4'b1000, 1'b0, 1'b1);
    set_ch(3, '0, 1'b0);
    step("prio_end", 4'b1000, 1'b1, 1'b1);
    step("prio_end", 4'b0000, 1'b0, 1'b0);
    bus.cfg_prio_en = 1'b0;
    chk("prio_drain", 64'(exp_q.size()), 64'd0);

    // Backpressure on ch0: stall after beat 2, then again on the final beat.
    base[0] = 32'h10 - cnt[0];  // next ch0 beat carries 0x10
    set_ch(0, 2'd1, 1'b1);
    step("bp", 4'b0000, 1'b0, 1'b0);
    step("bp", 4'b0001, 1'b0, 1'b1);
    step("bp", 4'b0001, 1'b1, 1'b1);
    bus.fifo_full = 1'b1;
    step("bp_full", 4'b0000, 1'b1, 1'b1);
    step("bp_full", 4'b0000, 1'b0, 1'b1);
    step("bp_full", 4'b0000, 1'b0, 1'b1);
    bus.fifo_full = 1'b0;
    step("bp", 4'b0001, 1'b0, 1'b1);
    bus.fifo_full = 1'b1;
    step("bp_last_full", 4'b0000, 1'b1, 1'b1);
    bus.fifo_full = 1'b0;
    step("bp", 4'b0001, 1'b0, 1'b1);
    set_ch(0, '0, 1'b0);
    step("bp_end", 4'b0000, 1'b1, 1'b0);
    chk("bp_drain", 64'(exp_q.size()), 64'd0);

    // Early release on ch2; ch0 also requests so only rr_ptr=3 selects ch3.
    set_ch(2, 2'd1, 1'b1);
    set_ch(3, 2'd1, 1'b1);
    step("rel", 4'b0000, 1'b0, 1'b0);
    step("rel", 4'b0100, 1'b0, 1'b1);
    step("rel", 4'b0100, 1'b1, 1'b1);
    set_ch(2, '0, 1'b0);
    set_ch(0, 2'd1, 1'b1);
    step("rel_drop", 4'b0100, 1'b1, 1'b1);
    step("rel_idle", 4'b0000, 1'b0, 1'b0);
    set_ch(0, '0, 1'b0);
    step("rel_ch3", 4'b1000, 1'b0, 1'b1);
    step("rel_ch3", 4'b1000, 1'b1, 1'b1);
    step("rel_ch3", 4'b1000, 1'b1, 1'b1);
    step("rel_ch3", 4'b1000, 1'b1, 1'b1);
    set_ch(3, '0, 1'b0);
    step("rel_end", 4'b0000, 1'b1, 1'b0);
    chk("rel_drain", 64'(exp_q.size()), 64'd0);

    // Abort mid-burst on ch1; afterwards rr_ptr=2 must pick ch2 over ch0/ch1.
    set_ch(1, 2'd2, 1'b1);
    step("abort", 4'b0000, 1'b0, 1'b0);
    step("abort", 4'b0010, 1'b0, 1'b1);
    step("abort", 4'b0010, 1'b1, 1'b1);
    bus.mstr_cmplt = 1'b1;
    set_ch(0, 2'd1, 1'b1);
    set_ch(2, 2'd1, 1'b1);
    step("abort_cyc", 4'b0000, 1'b1, 1'b1);
    step("abort_hold", 4'b0000, 1'b0, 1'b0);
    bus.mstr_cmplt = 1'b0;
    step("abort_arb", 4'b0000, 1'b0, 1'b0);
    step("abort_ch2", 4'b0100, 1'b0, 1'b1);
    all_off();
    step("abort_end", 4'b0100, 1'b1, 1'b1);
    step("abort_end", 4'b0000, 1'b0, 1'b0);
    chk("abort_drain", 64'(exp_q.size()), 64'd0);

    // Reset during a ch3 burst; first grant afterwards is the lowest requester.
    set_ch(1, 2'd1, 1'b1);
    set_ch(2, 2'd1, 1'b1);
    set_ch(3, 2'd1, 1'b1);
    step("rst", 4'b0000, 1'b0, 1'b0);
    step("rst", 4'b1000, 1'b0, 1'b1);
    step("rst", 4'b1000, 1'b1, 1'b1);
    rst = 1'b1;
    step("rst_cyc", 4'b1000, 1'b1, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("rst_after");
    @(posedge clk);
    #1;
    step("rst_regrant", 4'b0010, 1'b0, 1'b1);
    all_off();
    step("rst_end", 4'b0010, 1'b1, 1'b1);
    step("rst_end", 4'b0000, 1'b0, 1'b0);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
